// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with per-frame value snapshot,
// per-slot anode dead-time and a frame-done strobe. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int DEAD     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   snap, snap_nxt;
  logic          slot_end, boundary;
  logic [3:0]    nib;
  logic          suppress, dark;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Scan position and snapshot; value is only captured at the frame boundary.
  always_comb begin
    slot_end = (cnt == CNT_LAST);
    boundary = slot_end && (idx == 2'd3);
    cnt_nxt  = slot_end ? '0 : cnt + 1'b1;
    idx_nxt  = slot_end ? idx + 2'd1 : idx;
    snap_nxt = boundary ? value : snap;
  end

  always_comb begin
    case (idx)
      2'd0:    nib = snap[3:0];
      2'd1:    nib = snap[7:4];
      2'd2:    nib = snap[11:8];
      default: nib = snap[15:12];
    endcase
  end

`ifdef SEG7_LZB_EN
  assign suppress = ((idx == 2'd3) && (snap[15:12] == 4'h0)) ||
                    ((idx == 2'd2) && (snap[15:8] == 8'h00));
`else
  assign suppress = 1'b0;
`endif

  // dp rides on digit 2's anode so it goes dark with it.
  always_comb begin
    dark    = (cnt < CNT_DEAD) || blank || suppress;
    an_nxt  = dark ? 4'hF : ~(4'b0001 << idx);
    dp_nxt  = !((idx == 2'd2) && !dark);
    seg_nxt = decode(nib);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      snap       <= 16'h0000;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      snap       <= snap_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at SCAN_DIV=8, DEAD=2; expectations follow
// SEG7_LZB_EN when the bench is built with it defined.
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  // {seg_valid, frame_done, dp, an, seg} per output cycle of one frame
  logic [13:0] exp_q[$];

  seg7_scan_driver #(.SCAN_DIV(8), .DEAD(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b0111111;
    endcase
  endfunction

  // Checks one 32-cycle frame showing snapshot v, starting at a negedge where the
  // scan sits at cnt=0/idx=0. After sample chg_k value becomes chg_v; after sample
  // blk_k blank toggles (negative index = no event).
  task automatic check_frame(input int fr, input logic [15:0] v, input int chg_k,
                             input logic [15:0] chg_v, input int blk_k);
    int di, c;
    logic b, sup, dk, ed, ef;
    logic [3:0] nb, ea;
    logic [13:0] e;
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin
      di  = k / 8;
      c   = k % 8;
      b   = blank ^ ((blk_k >= 0) && (k > blk_k));
      nb  = 4'(v >> (4 * di));
`ifdef SEG7_LZB_EN
      sup = ((di == 3) && (v[15:12] == 4'h0)) || ((di == 2) && (v[15:8] == 8'h00));
`else
      sup = 1'b0;
`endif
      dk  = (c < 2) || b || sup;
      ea  = dk ? 4'hF : ~(4'(4'b0001 << di));
      ed  = ((di == 2) && !dk) ? 1'b0 : 1'b1;
      ef  = (k == 31);
      exp_q.push_back({!dk, ef, ed, ea, seg_of(nb)});
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("f%0d k%0d an", fr, k), 32'(an), 32'(e[10:7]));
      check($sformatf("f%0d k%0d dp", fr, k), 32'(dp), 32'(e[11]));
      check($sformatf("f%0d k%0d frame_done", fr, k), 32'(frame_done), 32'(e[12]));
      if (e[13]) check($sformatf("f%0d k%0d seg", fr, k), 32'(seg), 32'(e[6:0]));
      if (k == chg_k) value = chg_v;
      if (k == blk_k) blank = ~blank;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " an"}, 32'(an), 32'h0000000F);
    check({tag, " seg"}, 32'(seg), 32'h0000007F);
    check({tag, " dp"}, 32'(dp), 32'h00000001);
    check({tag, " frame_done"}, 32'(frame_done), 32'h00000000);
  endtask

  initial begin
    reset = 1'b1;
    value = 16'h5959;
    blank = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // Power-up frame shows zeros, then the 5959 snapshot
    check_frame(1, 16'h0000, -1, 16'h0000, -1);
    check_frame(2, 16'h5959, -1, 16'h0000, -1);

    // Reset at idx=2, cnt=5
    repeat (21) @(negedge clk);
    reset = 1'b1;
    value = 16'h1234;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    check_frame(3, 16'h0000, -1, 16'h0000, -1);

    // Mid-frame change 1234 -> 5678 is held off until the next boundary
    check_frame(4, 16'h1234, 12, 16'h5678, -1);

    // Blank for 64 cycles spanning three frames; snapshots keep updating underneath
    check_frame(5, 16'h5678, 3, 16'h00A0, 15);
    check_frame(6, 16'h00A0, 3, 16'h4300, -1);
    check_frame(7, 16'h4300, 3, 16'h00A0, 15);

    // Non-BCD nibble shows a dash, then leading zeros
    check_frame(8, 16'h00A0, 3, 16'h0009, -1);
    check_frame(9, 16'h0009, -1, 16'h0000, -1);

    // Reset landing on the boundary cycle suppresses frame_done
    repeat (31) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("boundary_reset");
    reset = 1'b0;
    @(negedge clk);
    check("post_reset frame_done", 32'(frame_done), 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
